// File: rtl/gpu_cmd_master.sv
// gpu_cmd_master: host-side initiator that serialises buffered write/read requests onto the GPU command bus.
// Latency: a write occupies the bus for 3*CLK_DIV cycles; a read for (3+2*READ_WAIT)*CLK_DIV, with the response pulse as it enters its last cmd_clk high phase.
// Backpressure: req_ready_out drops while the request FIFO is full (taken from the registered count), and the bus takes one FIFO entry per transaction.
//
// Ports: host request (req_*_in / req_ready_out), read response (rsp_*_out), busy_out,
//        GPU command bus split into drive/enable/input triples for the pad ring
//        (cmd_clk_out, cmd_inout_out, command_out/_oe_out, commandData_out/_oe_out/_in).
// Optional macro GPU_CMD_STATS_EN adds wr_count_out / rd_count_out completed-transaction counters.
module gpu_cmd_master #(
    parameter int CLK_DIV    = 2,
    parameter int READ_WAIT  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk_in,
    input  logic        reset_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_read_in,
    input  logic [15:0] req_cmd_in,
    input  logic [15:0] req_data_in,
    output logic        rsp_valid_out,
    output logic [15:0] rsp_cmd_out,
    output logic [15:0] rsp_data_out,
    output logic        busy_out,
    output logic        cmd_clk_out,
    output logic        cmd_inout_out,
    output logic [15:0] command_out,
    output logic        command_oe_out,
    output logic [15:0] commandData_out,
    output logic        commandData_oe_out,
    input  logic [15:0] commandData_in
`ifdef GPU_CMD_STATS_EN
    ,
    output logic [15:0] wr_count_out,
    output logic [15:0] rd_count_out
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(READ_WAIT + 1) + 1;

    typedef struct packed {
        logic        rd;
        logic [15:0] cmd;
        logic [15:0] data;
    } req_t;

    typedef enum logic [2:0] {IDLE, SETUP, CMD_HI, RD_LO, RD_HI, TAIL} state_t;

    // ---------------- request FIFO ----------------
    req_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    req_t          head;
    state_t        state_q;

    assign req_ready_out = (count_q != CW'(FIFO_DEPTH));
    assign push          = req_valid_in && req_ready_out;
    assign pop           = (state_q == IDLE) && (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign busy_out      = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge sys_clk_in) begin
        if (push)
            mem_q[wr_ptr_q] <= '{rd: req_read_in, cmd: req_cmd_in, data: req_data_in};
    end

    always_ff @(posedge sys_clk_in) begin
        if (!reset_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // ---------------- bus sequencer ----------------
    logic [DW-1:0] div_q;
    logic [EW-1:0] redge_q, redge_nxt;
    req_t          lat_q;
    logic          cmd_clk_q, cmd_inout_q, command_oe_q, cdata_oe_q, rsp_valid_q;
    logic [15:0]   command_q, cdata_q, rsp_cmd_q, rsp_data_q;
    logic          tc;
`ifdef GPU_CMD_STATS_EN
    logic [15:0]   wr_cnt_q, rd_cnt_q;
`endif

    assign tc        = (div_q == DW'(CLK_DIV - 1));
    assign redge_nxt = redge_q + EW'(1);

    always_ff @(posedge sys_clk_in) begin
        if (!reset_n_in) begin
            state_q      <= IDLE;
            div_q        <= '0;
            redge_q      <= '0;
            lat_q        <= '0;
            cmd_clk_q    <= 1'b0;
            cmd_inout_q  <= 1'b0;
            command_oe_q <= 1'b0;
            cdata_oe_q   <= 1'b0;
            command_q    <= '0;
            cdata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_cmd_q    <= '0;
            rsp_data_q   <= '0;
`ifdef GPU_CMD_STATS_EN
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            div_q       <= tc ? '0 : div_q + DW'(1);
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (pop) begin
                        lat_q        <= head;
                        state_q      <= SETUP;
                        command_oe_q <= 1'b1;
                        command_q    <= head.cmd;
                        cmd_inout_q  <= !head.rd;
                        cdata_oe_q   <= !head.rd;
                        cdata_q      <= head.rd ? 16'h0 : head.data;
                    end
                end
                SETUP: if (tc) begin
                    state_q   <= CMD_HI;
                    cmd_clk_q <= 1'b1;
                    redge_q   <= '0;
                end
                CMD_HI: if (tc) begin
                    cmd_clk_q <= 1'b0;
                    if (lat_q.rd) begin
                        state_q <= RD_LO;
                    end else begin
                        state_q <= TAIL;
`ifdef GPU_CMD_STATS_EN
                        wr_cnt_q <= wr_cnt_q + 16'd1;
`endif
                    end
                end
                RD_LO: if (tc) begin
                    state_q   <= RD_HI;
                    cmd_clk_q <= 1'b1;
                    redge_q   <= redge_nxt;
                    // Sample on the same sys_clk edge that raises the final read edge.
                    if (redge_nxt == EW'(READ_WAIT)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= commandData_in;
                        rsp_cmd_q   <= lat_q.cmd;
                    end
                end
                RD_HI: if (tc) begin
                    cmd_clk_q <= 1'b0;
                    if (redge_q == EW'(READ_WAIT)) begin
                        state_q <= TAIL;
`ifdef GPU_CMD_STATS_EN
                        rd_cnt_q <= rd_cnt_q + 16'd1;
`endif
                    end else begin
                        state_q <= RD_LO;
                    end
                end
                TAIL: if (tc) begin
                    // Drive values were held through TAIL for GPU hold time; release now.
                    state_q      <= IDLE;
                    cmd_inout_q  <= 1'b0;
                    command_oe_q <= 1'b0;
                    cdata_oe_q   <= 1'b0;
                    command_q    <= '0;
                    cdata_q      <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_out      = rsp_valid_q;
    assign rsp_cmd_out        = rsp_cmd_q;
    assign rsp_data_out       = rsp_data_q;
    assign cmd_clk_out        = cmd_clk_q;
    assign cmd_inout_out      = cmd_inout_q;
    assign command_out        = command_q;
    assign command_oe_out     = command_oe_q;
    assign commandData_out    = cdata_q;
    assign commandData_oe_out = cdata_oe_q;
`ifdef GPU_CMD_STATS_EN
    assign wr_count_out       = wr_cnt_q;
    assign rd_count_out       = rd_cnt_q;
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_gpu_cmd_master.sv
// tb_gpu_cmd_master: directed stimulus with a scoreboard; a negedge monitor checks every bus transaction and read response.
// Latency: expected transactions/responses are queued at request acceptance and popped when the DUT shows them.
// Backpressure: the push task holds req_valid_in until req_ready_out is seen, bounded by a cycle budget.
`timescale 1ns/1ps
module tb_gpu_cmd_master;

    logic        sys_clk_in = 1'b0;
    logic        reset_n_in;
    logic        req_valid_in, req_read_in;
    logic [15:0] req_cmd_in, req_data_in;
    logic        req_ready_out, rsp_valid_out, busy_out;
    logic [15:0] rsp_cmd_out, rsp_data_out;
    logic        cmd_clk_out, cmd_inout_out, command_oe_out, commandData_oe_out;
    logic [15:0] command_out, commandData_out;
    logic [15:0] commandData_in = 16'h0;
`ifdef GPU_CMD_STATS_EN
    logic [15:0] wr_count_out, rd_count_out;
`endif

    always #5 sys_clk_in = ~sys_clk_in;

    gpu_cmd_master #(.CLK_DIV(2), .READ_WAIT(2), .FIFO_DEPTH(4)) dut (
        .sys_clk_in(sys_clk_in), .reset_n_in(reset_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_read_in(req_read_in), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .rsp_valid_out(rsp_valid_out), .rsp_cmd_out(rsp_cmd_out), .rsp_data_out(rsp_data_out),
        .busy_out(busy_out), .cmd_clk_out(cmd_clk_out), .cmd_inout_out(cmd_inout_out),
        .command_out(command_out), .command_oe_out(command_oe_out),
        .commandData_out(commandData_out), .commandData_oe_out(commandData_oe_out),
        .commandData_in(commandData_in)
`ifdef GPU_CMD_STATS_EN
        , .wr_count_out(wr_count_out), .rd_count_out(rd_count_out)
`endif
    );

    typedef struct packed {
        logic        rd;
        logic [15:0] cmd;
        logic [15:0] data;
        logic [15:0] gpu;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] rsp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    txn_t cur;
    logic in_txn = 1'b0, have_cur = 1'b0, prev_clk = 1'b0, doe_bad = 1'b0;
    int   edges = 0, dur = 0, rsp_cnt = 0;

    always @(negedge sys_clk_in) begin
        if (!reset_n_in) begin
            in_txn = 1'b0; have_cur = 1'b0; prev_clk = 1'b0;
            commandData_in = 16'h0;
        end else begin
            if (command_oe_out && !in_txn) begin
                in_txn = 1'b1; have_cur = 1'b0; dur = 0; edges = 0; rsp_cnt = 0; doe_bad = 1'b0;
            end
            if (rsp_valid_out) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_cmd_data", {rsp_cmd_out, rsp_data_out}, rsp_q.pop_front());
            end
            if (command_oe_out) begin
                dur++;
                if (cmd_clk_out && !prev_clk) begin
                    edges++;
                    if (edges == 1) begin
                        if (txn_q.size() == 0) begin
                            chk("txn_unexpected", 1, 0);
                        end else begin
                            cur = txn_q.pop_front();
                            have_cur = 1'b1;
                            chk("cap_inout", cmd_inout_out, !cur.rd);
                            chk("cap_command", command_out, cur.cmd);
                            chk("cap_data_oe", commandData_oe_out, !cur.rd);
                            if (!cur.rd) chk("cap_wdata", commandData_out, cur.data);
                            else commandData_in = cur.gpu;
                        end
                    end
                end
                if (have_cur && cur.rd && commandData_oe_out) doe_bad = 1'b1;
            end else if (in_txn) begin
                in_txn = 1'b0;
                commandData_in = 16'h0;
                if (have_cur) begin
                    chk("edges", edges, cur.rd ? 3 : 1);
                    chk("duration", dur, cur.rd ? 14 : 6);
                    if (cur.rd) begin
                        chk("rsp_pulses", rsp_cnt, 1);
                        chk("rd_data_oe", doe_bad, 0);
                    end
                end
                chk("bus_idle", {cmd_clk_out, cmd_inout_out, commandData_oe_out, command_out, commandData_out}, 0);
            end
            prev_clk = cmd_clk_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic rd, input logic [15:0] cmd, input logic [15:0] data,
                        input logic [15:0] gpu, input logic exp_rsp, output int waited);
        logic rdy;
        int   n;
        rdy = 1'b0;
        req_valid_in = 1'b1; req_read_in = rd; req_cmd_in = cmd; req_data_in = data;
        for (n = 0; n < 200; n++) begin
            rdy = req_ready_out;
            @(posedge sys_clk_in); #1;
            if (rdy) break;
        end
        req_valid_in = 1'b0;
        waited = n;
        if (!rdy) chk("push_timeout", 0, 1);
        else begin
            txn_q.push_back('{rd: rd, cmd: cmd, data: data, gpu: gpu});
            if (rd && exp_rsp) rsp_q.push_back({cmd, gpu});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk_in); #1;
            if (!busy_out) break;
        end
        chk("drain_busy", busy_out, 0);
        repeat (2) @(posedge sys_clk_in);
        #1;
    endtask

    int w;
    logic pc;
    int rises;

    initial begin
        reset_n_in = 1'b0; req_valid_in = 1'b0; req_read_in = 1'b0;
        req_cmd_in = 16'h0; req_data_in = 16'h0;
        repeat (3) @(posedge sys_clk_in);
        #1;
        chk("rst_ctrl", {cmd_clk_out, cmd_inout_out, command_oe_out, commandData_oe_out, rsp_valid_out, busy_out}, 0);
        chk("rst_command", command_out, 0);
        chk("rst_cdata", commandData_out, 0);
        chk("rst_rsp", {rsp_cmd_out, rsp_data_out}, 0);
        chk("rst_ready", req_ready_out, 1);
        reset_n_in = 1'b1;
        repeat (2) @(posedge sys_clk_in);
        #1;
        chk("idle_busy", busy_out, 0);

        // single write, then single read
        push(1'b0, 16'h0305, 16'h8410, 16'h0, 1'b0, w);
        drain();
        push(1'b1, 16'h0305, 16'h0, 16'hF800, 1'b1, w);
        drain();
        chk("rsp_hold", {rsp_cmd_out, rsp_data_out}, {16'h0305, 16'hF800});

        // back-to-back burst fills the FIFO while the first write is on the bus
        push(1'b0, 16'h0101, 16'h1111, 16'h0, 1'b0, w);
        push(1'b1, 16'h0202, 16'h0, 16'h2222, 1'b1, w);
        push(1'b0, 16'h0303, 16'h3333, 16'h0, 1'b0, w);
        push(1'b1, 16'h0404, 16'h0, 16'h4444, 1'b1, w);
        push(1'b0, 16'h0505, 16'h5555, 16'h0, 1'b0, w);
        chk("full_ready", req_ready_out, 0);
        chk("full_busy", busy_out, 1);
        push(1'b0, 16'h0606, 16'h6666, 16'h0, 1'b0, w);
        chk("sixth_wait", w, 4);
        drain();
`ifdef GPU_CMD_STATS_EN
        chk("stat_wr", wr_count_out, 5);
        chk("stat_rd", rd_count_out, 3);
`endif

        // reset in the first RD_HI of a read, with a write still queued
        push(1'b1, 16'h0707, 16'h0, 16'h7777, 1'b0, w);
        push(1'b0, 16'h0808, 16'h8888, 16'h0, 1'b0, w);
        rises = 0; pc = cmd_clk_out;
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk_in); #1;
            if (cmd_clk_out && !pc) rises++;
            pc = cmd_clk_out;
            if (rises == 2) break;
        end
        chk("abort_reach_rdhi", rises, 2);
        reset_n_in = 1'b0;
        @(posedge sys_clk_in); #1;
        chk("abort_ctrl", {cmd_clk_out, cmd_inout_out, command_oe_out, commandData_oe_out, rsp_valid_out, busy_out}, 0);
        chk("abort_bus", {command_out, commandData_out}, 0);
        chk("abort_ready", req_ready_out, 1);
        reset_n_in = 1'b1;
        txn_q.delete();
        repeat (20) @(posedge sys_clk_in);
        #1;
        chk("abort_busy", busy_out, 0);
        chk("abort_rsp_hold", {rsp_cmd_out, rsp_data_out}, 0);

        push(1'b0, 16'h0909, 16'h9999, 16'h0, 1'b0, w);
        drain();
`ifdef GPU_CMD_STATS_EN
        chk("stat_wr_after_rst", wr_count_out, 1);
        chk("stat_rd_after_rst", rd_count_out, 0);
`endif
        chk("txn_q_empty", txn_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
